// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   if_req/if_addr -> if_rdata/if_ack   fetch request and one-cycle completion
//   d_req/d_we/d_addr/d_wdata/d_be      data request (load/store)
//   d_rdata/d_ack                       load data and one-cycle completion
//   mem_req/we/addr/wdata/be            registered memory-side request
//   mem_rdata/mem_ack                   memory response
//   stall_if, stall_mem                 pipeline stalls (combinational)
//   bus_err                             flags the ack of a timed-out transaction
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_be,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, RESP, ERR} state_t;
    state_t state, state_n;
    logic last_d, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic req_n, we_n, if_ack_n, d_ack_n, err_n, pick_d;
    logic [ADDR_W-1:0] addr_n;
    logic [XLEN-1:0] wdata_n, if_rdata_n, d_rdata_n;
    logic [XLEN/8-1:0] be_n;
    // On contention the side that did not win last time gets the port
    assign pick_d = d_req & (~if_req | ~last_d);
    assign stall_if = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;
    always_comb begin
        state_n = state;
        last_n = last_d;
        cnt_n = cnt;
        req_n = mem_req;
        we_n = mem_we;
        addr_n = mem_addr;
        wdata_n = mem_wdata;
        be_n = mem_be;
        if_ack_n = 1'b0;
        d_ack_n = 1'b0;
        err_n = 1'b0;
        if_rdata_n = if_rdata;
        d_rdata_n = d_rdata;
        case (state)
            IDLE: if (if_req | d_req) begin
                state_n = pick_d ? GRANT_D : GRANT_I;
                last_n = pick_d;
                cnt_n = '0;
                req_n = 1'b1;
                we_n = pick_d & d_we;
                addr_n = pick_d ? d_addr : if_addr;
                wdata_n = pick_d ? d_wdata : '0;
                be_n = pick_d ? d_be : '1;
            end
            GRANT_I, GRANT_D: begin
                // ack is checked before the timeout so a last-cycle ack completes normally
                if (mem_ack) begin
                    state_n = RESP;
                    req_n = 1'b0;
                    if_ack_n = (state == GRANT_I);
                    d_ack_n = (state == GRANT_D);
                    if_rdata_n = (state == GRANT_I) ? mem_rdata : if_rdata;
                    d_rdata_n = (state == GRANT_D) ? (mem_we ? '0 : mem_rdata) : d_rdata;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = ERR;
                    req_n = 1'b0;
                    err_n = 1'b1;
                    if_ack_n = (state == GRANT_I);
                    d_ack_n = (state == GRANT_D);
                    if_rdata_n = (state == GRANT_I) ? '0 : if_rdata;
                    d_rdata_n = (state == GRANT_D) ? '0 : d_rdata;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last_d <= 1'b0;
            cnt <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_be <= '0;
            if_ack <= 1'b0;
            d_ack <= 1'b0;
            bus_err <= 1'b0;
            if_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= state_n;
            last_d <= last_n;
            cnt <= cnt_n;
            mem_req <= req_n;
            mem_we <= we_n;
            mem_addr <= addr_n;
            mem_wdata <= wdata_n;
            mem_be <= be_n;
            if_ack <= if_ack_n;
            d_ack <= d_ack_n;
            bus_err <= err_n;
            if_rdata <= if_rdata_n;
            d_rdata <= d_rdata_n;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector bench for mem_port_arbiter (TIMEOUT=4)
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0] d_be = 0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    logic if_ack, d_ack, mem_req, mem_we, stall_if, stall_mem, bus_err;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    typedef struct {
        string nm;
        logic ir; logic [31:0] ia;
        logic dr, dw; logic [31:0] da, dd; logic [3:0] db;
        logic ma; logic [31:0] mr;
        logic er, ew; logic [31:0] ea, ed; logic [3:0] eb;
        logic eia, eda; logic [31:0] erd; logic eer;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input string nm, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic [3:0] db, input logic ma, input logic [31:0] mr,
                       input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] eb, input logic eia, input logic eda,
                       input logic [31:0] erd, input logic eer);
        vec_t v;
        v.nm = nm; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.db = db;
        v.ma = ma; v.mr = mr; v.er = er; v.ew = ew; v.ea = ea; v.ed = ed; v.eb = eb;
        v.eia = eia; v.eda = eda; v.erd = erd; v.eer = eer;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic ok;
        if_req = v.ir; if_addr = v.ia; d_req = v.dr; d_we = v.dw; d_addr = v.da;
        d_wdata = v.dd; d_be = v.db; mem_ack = v.ma; mem_rdata = v.mr;
        @(negedge clk);
        ok = mem_req === v.er && mem_we === v.ew && mem_addr === v.ea && mem_wdata === v.ed &&
             mem_be === v.eb && if_ack === v.eia && d_ack === v.eda && bus_err === v.eer &&
             stall_if === (v.ir & ~v.eia) && stall_mem === (v.dr & ~v.eda) &&
             (!v.eia || if_rdata === v.erd) && (!v.eda || d_rdata === v.erd);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s[%0d]: got req=%b we=%b addr=%h wd=%h be=%h iack=%b dack=%b ird=%h drd=%h err=%b sif=%b smem=%b; want req=%b we=%b addr=%h wd=%h be=%h iack=%b dack=%b rd=%h err=%b sif=%b smem=%b",
                     v.nm, idx, mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack,
                     if_rdata, d_rdata, bus_err, stall_if, stall_mem,
                     v.er, v.ew, v.ea, v.ed, v.eb, v.eia, v.eda, v.erd, v.eer,
                     v.ir & ~v.eia, v.dr & ~v.eda);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pa, pw, a, w;
        logic d;
        add("cont0", 1, 'h100, 1, 0, 'h2000, 0, 'hF, 1, 'hAAAA0001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("cont1", 1, 'h100, 1, 0, 'h2000, 0, 'hF, 1, 'hAAAA0001, 1, 0, 'h2000, 0, 'hF, 0, 0, 0, 0);
        add("cont2", 1, 'h100, 1, 0, 'h2000, 0, 'hF, 1, 'hAAAA0001, 0, 0, 'h2000, 0, 'hF, 0, 1, 'hAAAA0001, 0);
        add("cont3", 1, 'h100, 0, 0, 0, 0, 0, 1, 'hAAAA0001, 0, 0, 'h2000, 0, 'hF, 0, 0, 0, 0);
        add("cont4", 1, 'h100, 0, 0, 0, 0, 0, 1, 'h00500093, 1, 0, 'h100, 0, 'hF, 0, 0, 0, 0);
        add("cont5", 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h100, 0, 'hF, 1, 0, 'h00500093, 0);
        add("cont6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h100, 0, 'hF, 0, 0, 0, 0);
        pa = 'h100; pw = 0;
        for (int t = 0; t < 6; t++) begin
            d = (t % 2 == 0);
            a = d ? 32'h2008 : 32'h104;
            w = d ? 32'h55 : 32'h0;
            add("rr_idle", 1, 'h104, 1, 0, 'h2008, 'h55, 'hF, 1, 'h12345678, 0, 0, pa, pw, 'hF, 0, 0, 0, 0);
            add("rr_grant", 1, 'h104, 1, 0, 'h2008, 'h55, 'hF, 1, 'h12345678, 1, 0, a, w, 'hF, 0, 0, 0, 0);
            add("rr_ack", 1, 'h104, 1, 0, 'h2008, 'h55, 'hF, 1, 'h12345678, 0, 0, a, w, 'hF, ~d, d, 'h12345678, 0);
            pa = a; pw = w;
        end
        add("rr_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h104, 0, 'hF, 0, 0, 0, 0);
        add("st_idle", 0, 0, 1, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 0, 0, 'h104, 0, 'hF, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            add("st_wait", 0, 0, 1, 1, 'h3004, 'hDEADBEEF, 'h3, k == 3, 'hFFFFFFFF, 1, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 0, 0);
        add("st_ack", 0, 0, 1, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 0, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 1, 0, 0);
        add("st_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 0, 0);
        add("to_idle", 1, 'h200, 0, 0, 0, 0, 0, 0, 'h77777777, 0, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            add("to_wait", 1, 'h200, 0, 0, 0, 0, 0, 0, 'h77777777, 1, 0, 'h200, 0, 'hF, 0, 0, 0, 0);
        add("to_err", 1, 'h200, 0, 0, 0, 0, 0, 0, 'h77777777, 0, 0, 'h200, 0, 'hF, 1, 0, 0, 1);
        add("to_end", 0, 0, 0, 0, 0, 0, 0, 1, 'h77777777, 0, 0, 'h200, 0, 'hF, 0, 0, 0, 0);
        add("la_idle", 1, 'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h200, 0, 'hF, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            add("la_wait", 1, 'h204, 0, 0, 0, 0, 0, k == 3, 'h0BADF00D, 1, 0, 'h204, 0, 'hF, 0, 0, 0, 0);
        add("la_ack", 1, 'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h204, 0, 'hF, 1, 0, 'h0BADF00D, 0);
        add("la_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h204, 0, 'hF, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 32'({mem_req, mem_we, if_ack, d_ack, bus_err, mem_be}), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        d_req = 1; d_we = 0; d_addr = 'h4000; d_be = 'hF; mem_ack = 0;
        @(posedge clk);
        #1 check("mid_grant", 32'({mem_req, mem_we}), 32'b10);
        check("mid_addr", mem_addr, 'h4000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_ctl", 32'({mem_req, d_ack, bus_err}), 0);
        check("async_rst_addr", mem_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1; d_req = 0; mem_ack = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_stale_ack", 32'({mem_req, if_ack, d_ack, bus_err}), 0);
            @(posedge clk);
            #1;
        end
        mem_ack = 0; if_req = 1; if_addr = 'h300; d_req = 1; d_addr = 'h4000;
        @(posedge clk);
        #1 check("post_rst_data_first", 32'({mem_req, mem_we}), 32'b10);
        check("post_rst_addr", mem_addr, 'h4000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequencer and arbiter that shares the core's single unified memory port between instruction fetch (IF stage) and data access (MEM stage; loads/stores flagged by the control unit's MemToReg/MemWrite).
- Grants one requester at a time, drives the memory-side handshake and returns read data with a one-cycle ack pulse.
- Generates stall signals for the pipeline and a timeout error for hung memory.

Parameters:
ADDR_W, 32, address width
XLEN, 32, data width
TIMEOUT, 255, max cycles mem_req may stay high without mem_ack (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  XLEN  fetched instruction, valid when if_ack=1
if_ack  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  XLEN  store data
d_be  in  XLEN/8  byte enables
d_rdata  out  XLEN  load data, valid when d_ack=1
d_ack  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  registered address
mem_wdata  out  XLEN  registered write data
mem_be  out  XLEN/8  byte enables (all ones for fetch)
mem_rdata  in  XLEN  read data, valid with mem_ack
mem_ack  in  1  memory completion
stall_if  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  d_req & ~d_ack (combinational)
bus_err  out  1  high in same cycle as the ack pulse of a timed-out transaction

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RESP, ERR. All other outputs registered.
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, if_ack, d_ack, bus_err = 0; mem_addr, mem_wdata, if_rdata, d_rdata, timeout counter = 0; mem_be = 0; last_grant = FETCH. An in-flight transaction is abandoned, and no ack is issued for it after release.
- IDLE, cycle N:
  - Only d_req set -> GRANT_D. Only if_req set -> GRANT_I.
  - Both set -> grant the requester not equal to last_grant. After reset, data wins.
  - On grant: latch address/data/be/we; mem_req=1 from cycle N+1; last_grant updated.
  - Fetch always drives mem_we=0 and mem_be=all ones.
- GRANT_x: mem_req held with stable fields.
  - mem_ack=1 in cycle K: capture mem_rdata; go to RESP.
  - RESP, cycle K+1: mem_req=0; x_ack=1; x_rdata=captured data (zero for stores); bus_err=0.
  - RESP -> IDLE. Earliest new grant starts mem_req at K+3.
  - Zero-wait memory (ack in first mem_req cycle): 3 cycles request-to-ack per transaction.
- Timeout:
  - Counter clears on grant and increments each GRANT cycle without mem_ack.
  - After TIMEOUT consecutive mem_req cycles with no ack -> ERR. ERR cycle: mem_req=0, x_ack=1, bus_err=1, x_rdata=0; then IDLE.
  - mem_ack arriving in the final allowed cycle is accepted normally (ack wins over timeout).
- Boundary rules:
  - mem_ack outside GRANT states is ignored.
  - If a requester drops req mid-transaction, the transaction still completes and the ack still pulses; the requester must ignore it.
  - A requester whose ack pulses in cycle K+1 may re-request in K+1. The arbiter samples requests only in IDLE, so back-to-back same-source requests alternate with the other source when both are pending.
  - if_ack and d_ack are never high in the same cycle.

Test Plan:
- Fetch only, zero-wait memory: if_req=1, if_addr=0x100 at cycle 0; mem_ack=1, mem_rdata=0x00500093 at cycle 1 -> mem_req=1, mem_addr=0x100, mem_be=4'hF at cycle 1; if_ack=1, if_rdata=0x00500093 at cycle 2; stall_if high cycles 0-1.
- Contention after reset: if_req and d_req (load, addr 0x2000) both high at cycle 0 -> data granted first (mem_addr=0x2000, mem_we=0), then fetch granted; acks never overlap; stall_if stays high through the data transaction.
- Round robin: both requesters continuously re-requesting for 6 transactions -> grant order D,I,D,I,D,I.
- Store with byte enables: d_we=1, d_addr=0x3004, d_wdata=0xDEADBEEF, d_be=4'b0011, mem_ack after 3 wait cycles -> mem_* fields match and stay stable for 4 cycles; d_ack one cycle after mem_ack; d_rdata=0.
- Timeout, TIMEOUT=4, mem_ack tied 0: mem_req high exactly 4 cycles, then if_ack=1 and bus_err=1 with if_rdata=0 in the next cycle, then IDLE. Rerun with mem_ack in the 4th cycle -> normal ack, bus_err=0.
- Reset mid-transaction: assert rst_n=0 while GRANT_D with mem_req=1 -> mem_req, d_ack and bus_err drop immediately (asynchronously); after release, no ack is issued, and the next simultaneous request grants data first.
